// File: rtl/mem_stage_dcache_if.sv
// MEM stage <-> data cache <-> backing memory bundle.
// master drives requests and memory responses; slave is the cache.
interface mem_stage_dcache_if;
  logic            req_valid;
  logic            req_we;
  logic            is_LB_SB;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [0:3][7:0] cache_data_out;
  logic [1:0]      mem_block;
  logic            done;
  logic            stall;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_be;
  logic [31:0]     mem_rdata;
  logic            mem_ready;

  modport master (
    output req_valid, req_we, is_LB_SB, addr, wdata,
    output mem_rdata, mem_ready,
    input  cache_data_out, mem_block, done, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req_valid, req_we, is_LB_SB, addr, wdata,
    input  mem_rdata, mem_ready,
    output cache_data_out, mem_block, done, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_stage_dcache.sv
// Direct-mapped write-through no-allocate D-cache, MEM stage.
// One-word lines; refills and stores go out over req/ready.
module mem_stage_dcache #(
  parameter int INDEX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  mem_stage_dcache_if.slave  bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TW    = 30 - INDEX_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]            state;
  logic [0:3][7:0]       data_q [LINES];
  logic [TW-1:0]         tag_q  [LINES];
  logic [LINES-1:0]      valid_q;
  logic [31:0]           a_q;

  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] fidx;
  logic [TW-1:0]         tag;
  logic [TW-1:0]         ftag;
  logic                  hit;
  logic                  idle_req;
  logic                  ld_hit;
  logic                  ld_miss;
  logic                  st_req;
  logic                  st_hit;
  logic                  fill_done;
  logic                  wr_done;

  assign idx  = bus.addr[INDEX_BITS+1:2];
  assign tag  = bus.addr[31:INDEX_BITS+2];
  assign fidx = a_q[INDEX_BITS+1:2];
  assign ftag = a_q[31:INDEX_BITS+2];

  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign idle_req  = (state == IDLE) && bus.req_valid;
  assign ld_hit    = idle_req && !bus.req_we && hit;
  assign ld_miss   = idle_req && !bus.req_we && !hit;
  assign st_req    = idle_req && bus.req_we;
  assign st_hit    = st_req && hit;
  assign fill_done = (state == FILL) && bus.mem_ready;
  assign wr_done   = (state == WRITE) && bus.mem_ready;

  assign bus.stall = (state != IDLE) || (idle_req && !ld_hit);

  // FSM, memory port and load result registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state              <= IDLE;
      valid_q            <= '0;
      a_q                <= '0;
      bus.cache_data_out <= '0;
      bus.mem_block      <= '0;
      bus.done           <= 1'b0;
      bus.mem_req        <= 1'b0;
      bus.mem_we         <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_wdata      <= '0;
      bus.mem_be         <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) a_q <= bus.addr;
          unique case (1'b1)
            ld_hit: begin
              bus.cache_data_out <= data_q[idx];
              bus.mem_block      <= bus.addr[1:0];
              bus.done           <= 1'b1;
            end
            ld_miss: begin
              state         <= FILL;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b0;
              bus.mem_be    <= 4'hF;
              bus.mem_addr  <= {bus.addr[31:2], 2'b00};
            end
            st_req: begin
              state         <= WRITE;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {bus.addr[31:2], 2'b00};
              if (bus.is_LB_SB) begin
                bus.mem_be    <= 4'b0001 << bus.addr[1:0];
                bus.mem_wdata <= {4{bus.wdata[7:0]}};
              end else begin
                bus.mem_be    <= 4'hF;
                bus.mem_wdata <= bus.wdata;
              end
            end
            default: ;
          endcase
        end
        FILL: begin
          if (bus.mem_ready) begin
            state              <= IDLE;
            valid_q[fidx]      <= 1'b1;
            bus.cache_data_out <= bus.mem_rdata;
            bus.mem_block      <= a_q[1:0];
            bus.done           <= 1'b1;
            bus.mem_req        <= 1'b0;
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            state       <= IDLE;
            bus.done    <= 1'b1;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // line storage: store-hit update and refill write
  always_ff @(posedge clk) begin
    if (st_hit) begin
      if (bus.is_LB_SB)
        data_q[idx][bus.addr[1:0]] <= bus.wdata[7:0];
      else
        data_q[idx] <= bus.wdata;
    end else if (fill_done) begin
      data_q[fidx] <= bus.mem_rdata;
      tag_q[fidx]  <= ftag;
    end
  end

  logic unused_ok;
  assign unused_ok = wr_done;
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed bench for mem_stage_dcache with a result scoreboard.
// Bench plays both the MEM stage and the backing memory.
module tb_mem_stage_dcache;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mem_stage_dcache_if bus ();

  mem_stage_dcache #(.INDEX_BITS(4)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  blk;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; called at a negedge, returns at a negedge.
  // dly<0 means mem_ready is already high before the request.
  task automatic access(input string tag, input bit we, input bit bt,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit fast, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] rd,
                        input int dly, input logic [31:0] eld,
                        input logic [1:0] eblk);
    exp_t e;
    bit seen;
    bit got;
    int k;
    e.data = eld;
    e.blk  = eblk;
    sb.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.is_LB_SB  = bt;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.mem_rdata = rd;
    bus.mem_ready = (dly < 0);
    #1;
    chk({tag, "_stall_in"}, bus.stall, fast ? 0 : 1);
    seen = 0;
    got  = 0;
    k    = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        e = sb.pop_front();
        chk({tag, "_data"}, bus.cache_data_out, e.data);
        chk({tag, "_blk"}, bus.mem_block, e.blk);
        chk({tag, "_traffic"}, seen, fast ? 0 : 1);
        if (fast) chk({tag, "_hit_lat"}, c, 0);
        else chk({tag, "_min_lat"}, c >= 1, 1);
      end else if (bus.mem_req) begin
        chk({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
        chk({tag, "_we"}, bus.mem_we, we);
        chk({tag, "_be"}, bus.mem_be, ebe);
        if (we) chk({tag, "_wdata"}, bus.mem_wdata, ewd);
        chk({tag, "_stall_busy"}, bus.stall, 1);
        if (seen) k++;
        seen = 1;
        if (k == dly) bus.mem_ready = 1'b1;
      end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_once"}, bus.done, 0);
    chk({tag, "_stall_idle"}, bus.stall, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.is_LB_SB  = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.cache_data_out, 0);
    chk("rst_blk", bus.mem_block, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_be", bus.mem_be, 0);
    chk("rst_stall", bus.stall, 0);
    rst_b = 1'b1;
    @(negedge clk);

    access("lw100", 0, 0, 32'h100, 0, 0, 4'hF, 0,
           32'h11223344, 3, 32'h11223344, 2'd0);
    access("lb102", 0, 1, 32'h102, 0, 1, 4'hF, 0,
           0, 0, 32'h11223344, 2'd2);
    access("sb101", 1, 1, 32'h101, 32'h000000AB, 0, 4'b0010,
           32'hABABABAB, 0, 1, 32'h11223344, 2'd2);
    access("lw100b", 0, 0, 32'h100, 0, 1, 4'hF, 0,
           0, 0, 32'h11AB3344, 2'd0);
    access("sw200", 1, 0, 32'h200, 32'hDEADBEEF, 0, 4'hF,
           32'hDEADBEEF, 0, 0, 32'h11AB3344, 2'd0);
    access("lw200", 0, 0, 32'h200, 0, 0, 4'hF, 0,
           32'hCAFEF00D, 2, 32'hCAFEF00D, 2'd0);
    access("lw100c", 0, 0, 32'h100, 0, 0, 4'hF, 0,
           32'h11AB3344, -1, 32'h11AB3344, 2'd0);
    access("lw140", 0, 0, 32'h140, 0, 0, 4'hF, 0,
           32'h55667788, 1, 32'h55667788, 2'd0);
    access("lw100d", 0, 0, 32'h100, 0, 0, 4'hF, 0,
           32'h11AB3344, 0, 32'h11AB3344, 2'd0);
    access("lb103", 0, 1, 32'h103, 0, 1, 4'hF, 0,
           0, 0, 32'h11AB3344, 2'd3);
    access("sw100", 1, 0, 32'h100, 32'h01020304, 0, 4'hF,
           32'h01020304, 0, 2, 32'h11AB3344, 2'd3);
    access("lw100e", 0, 0, 32'h100, 0, 1, 4'hF, 0,
           0, 0, 32'h01020304, 2'd0);

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.is_LB_SB  = 1'b0;
    bus.addr      = 32'h180;
    @(negedge clk);
    chk("rfill_req", bus.mem_req, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("rfill_req_drop", bus.mem_req, 0);
    chk("rfill_data", bus.cache_data_out, 0);
    chk("rfill_blk", bus.mem_block, 0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    access("lw100f", 0, 0, 32'h100, 0, 0, 4'hF, 0,
           32'h01020304, 1, 32'h01020304, 2'd0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_dcache.md
Name: mem_stage_dcache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache serving the MEM stage of the MIPS pipeline.
- Produces the byte-lane load data (cache_data_out[0:3]) and byte selector (mem_block) that the WB stage consumes for LW/LB.
- Handles SW/SB stores and refills one-word lines from backing memory over a req/ready handshake.
- Stalls the pipeline while a miss or store is outstanding.

Parameters:
INDEX_BITS, 4, line index width; 2**INDEX_BITS one-word (4-byte) lines; tag = addr[31:INDEX_BITS+2]

Ports:
clk  in  1  clock
rst_b  in  1  reset, asynchronous, active-low
req_valid  in  1  MEM stage presents a load/store this cycle
req_we  in  1  1 = store, 0 = load
is_LB_SB  in  1  byte access (LB/SB) when 1, word access when 0
addr  in  32  byte address
wdata  in  32  store data; SB uses wdata[7:0]
cache_data_out  out  8 x [0:3]  load word, lane i = byte at offset i; lane 0 = word[31:24]
mem_block  out  2  addr[1:0] of the completed load
done  out  1  one-cycle pulse when a request completes
stall  out  1  pipeline must hold the MEM request
mem_req  out  1  backing-memory request
mem_we  out  1  backing-memory write
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  write data
mem_be  out  4  byte enables, bit i = lane i
mem_rdata  in  32  refill data, lane 0 = [31:24]
mem_ready  in  1  backing memory accepts/completes the current request

Behaviour:
- Reset (async): state IDLE; all valid bits 0; cache_data_out all 8'h00; mem_block 0; done 0; mem_req 0; mem_we 0; mem_addr 0; mem_wdata 0; mem_be 0.
- Reset mid-operation: transaction abandoned; mem_req drops immediately; no line is written.
- Request capture: in IDLE with req_valid=1, latch addr, req_we, is_LB_SB, wdata. Requests in other states are ignored; the pipeline holds them stable while stall=1.
- FSM states: IDLE, FILL, WRITE.
- IDLE, load hit (valid and tag match): next edge loads cache_data_out from the line, sets mem_block=addr[1:0], pulses done. State stays IDLE. Latency 1 cycle, no memory traffic.
- IDLE, load miss: next edge enters FILL with mem_req=1, mem_we=0, mem_be=4'hF, mem_addr word-aligned.
- FILL: hold all mem_* outputs stable until mem_ready=1. On that edge:
  - write line data, tag, valid;
  - drive cache_data_out from mem_rdata and mem_block from latched addr[1:0];
  - pulse done; mem_req=0; return to IDLE.
- IDLE, store: next edge enters WRITE with mem_req=1, mem_we=1.
  - SW: mem_be=4'hF, mem_wdata=wdata, addr[1:0] ignored.
  - SB: mem_be one-hot at lane addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - If the line hits, update it on the same edge: full word for SW, only lane addr[1:0] for SB. A store miss does not allocate.
- WRITE: hold mem_* until mem_ready=1. On that edge: pulse done, mem_req=0, return to IDLE. cache_data_out and mem_block are unchanged by stores.
- stall (combinational) = (state != IDLE) OR (state==IDLE AND req_valid AND NOT load hit). It falls in the cycle done pulses.
- mem_ready is ignored in IDLE.
- mem_ready may already be high on the first FILL/WRITE cycle; minimum miss/store latency is 2 cycles.
- Conflicting index: refill overwrites the line unconditionally. No dirty state exists (write-through).
- Back-to-back: a new request may be accepted in the cycle after done.

Test Plan:
- Reset, then LW addr 0x100; mem_ready high 3 cycles after mem_req with mem_rdata=0x11223344.
  -> mem_req high with mem_addr=0x100, mem_we=0; stall high throughout.
  -> on completion cache_data_out={11,22,33,44}, done pulses exactly once.
- LB addr 0x102 right after the fill.
  -> hit: no mem_req; done 1 cycle after acceptance; mem_block=2; cache_data_out={11,22,33,44}; stall never high.
- SB addr 0x101 wdata 0x000000AB, then LW 0x100.
  -> store: mem_we=1, mem_be=4'b0010, mem_wdata=0xABABABAB, mem_addr=0x100.
  -> following load hits with {11,AB,33,44}.
- SW addr 0x200 wdata 0xDEADBEEF (not cached), then LW 0x200.
  -> write-through with mem_be=4'hF; load still misses (no allocate); refill returns mem_rdata.
- LW 0x100 (fill), LW 0x140 (same index, INDEX_BITS=4), LW 0x100.
  -> three misses, each issuing mem_req.
  -> 0x140 evicts 0x100.
- Assert rst_b low during FILL of 0x100, release, then LW 0x100.
  -> mem_req drops asynchronously; cache_data_out=0; subsequent load misses.
